sisc_mc_ctrl: RTL and testbench

//   Parametrised multi-cycle control sequencer for the sisc datapath. Replaces the single-state fsm.

---
 rtl/sisc_mc_ctrl_if.sv | 45 ++++
 rtl/sisc_mc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sisc_mc_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sisc_mc_ctrl_if.sv
// Control bundle between the sisc multi-cycle sequencer and the datapath/memory side.
// The master modport is the sequencer; the slave modport is the datapath and memories.
interface sisc_mc_ctrl_if #(
    parameter int OPC_W = 4,
    parameter int MM_W  = 4,
    parameter int CC_W  = 4,
    parameter int CNT_W = 16
);
    // Handshakes: if_req/dm_req are held high until the matching ack is seen in a
    // cycle where the request is high; an ack with no request pending is ignored.
    logic             if_ack;
    logic [OPC_W-1:0] opcode;
    logic [MM_W-1:0]  mm;
    logic [CC_W-1:0]  stat;
    logic             dm_ack;

    logic             if_req;
    logic             ir_load;
    logic             pc_we;
    logic             pc_sel;
    logic [1:0]       alu_op;
    logic             cc_en;
    logic             dm_req;
    logic             dm_we;
    logic             rf_we;
    logic             wb_sel;
    logic             rd_sel;
    logic             halted;
    logic             err_ill;
    logic             err_tmo;
    logic [CNT_W-1:0] instr_cnt;
    logic [2:0]       state_dbg;

    modport master (
        input  if_ack, opcode, mm, stat, dm_ack,
        output if_req, ir_load, pc_we, pc_sel, alu_op, cc_en, dm_req, dm_we,
               rf_we, wb_sel, rd_sel, halted, err_ill, err_tmo, instr_cnt, state_dbg
    );

    modport slave (
        output if_ack, opcode, mm, stat, dm_ack,
        input  if_req, ir_load, pc_we, pc_sel, alu_op, cc_en, dm_req, dm_we,
               rf_we, wb_sel, rd_sel, halted, err_ill, err_tmo, instr_cnt, state_dbg
    );
endinterface

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the sisc core,
// with branch-on-status, HALT, illegal-opcode and data-memory timeout handling.
module sisc_mc_ctrl #(
    parameter int OPC_W   = 4,
    parameter int MM_W    = 4,
    parameter int CC_W    = 4,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           rst,
    sisc_mc_ctrl_if.master bus
);
    localparam int TMO_W = ($clog2(MEM_TMO + 1) > 0) ? $clog2(MEM_TMO + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_RR   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_RI   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_MEM  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_HALT = {OPC_W{1'b1}};

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] op_q;
    logic [MM_W-1:0]  mm_q;
    logic [TMO_W-1:0] wait_cnt;
    logic [CNT_W-1:0] instr_cnt;

    logic is_nop, is_halt, is_legal, is_store, br_taken, tmo_hit, retire;

    assign is_nop   = (op_q == OP_NOP);
    assign is_halt  = (op_q == OP_HALT);
    assign is_legal = is_nop || is_halt || (op_q == OP_RR) || (op_q == OP_RI) ||
                      (op_q == OP_MEM) || (op_q == OP_BR);
    assign is_store = mm_q[0];

    // An empty condition mask means an unconditional branch.
    assign br_taken = (mm_q[CC_W-1:0] == '0) || (|(bus.stat & mm_q[CC_W-1:0]));

    // An ack arriving on the limit cycle suppresses the timeout.
    assign tmo_hit = (MEM_TMO != 0) && (state == S_MEM) && !bus.dm_ack &&
                     (wait_cnt == TMO_LAST);

    assign retire = (state == S_WRITEBACK) ||
                    ((state == S_EXECUTE) && (op_q == OP_BR)) ||
                    ((state == S_MEM) && bus.dm_ack && is_store) ||
                    ((state == S_DECODE) && (is_nop || is_halt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            mm_q      <= '0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            if (retire && (instr_cnt != {CNT_W{1'b1}})) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            case (state)
                S_FETCH: begin
                    if (bus.if_ack) begin
                        op_q  <= bus.opcode;
                        mm_q  <= bus.mm;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else if (is_nop || !is_legal) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    wait_cnt <= '0;
                    if (op_q == OP_MEM) begin
                        state <= S_MEM;
                    end else if (op_q == OP_BR) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (bus.dm_ack) begin
                        state <= is_store ? S_FETCH : S_WRITEBACK;
                    end else if (tmo_hit) begin
                        state <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_FETCH;
            endcase
        end
    end

    logic       if_req, ir_load, pc_we, pc_sel, cc_en, dm_req, dm_we;
    logic       rf_we, wb_sel, rd_sel, halted, err_ill, err_tmo;
    logic [1:0] alu_op;

    // IR_LOAD/PC_WE follow IF_ACK combinationally in FETCH; reset masks them so an
    // ack during reset cannot load the IR or step the PC.
    always_comb begin
        if_req  = 1'b0;
        ir_load = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        alu_op  = 2'b00;
        cc_en   = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = 1'b0;
        rd_sel  = 1'b0;
        halted  = 1'b0;
        err_ill = 1'b0;
        err_tmo = 1'b0;
        case (state)
            S_FETCH: begin
                if_req  = 1'b1;
                ir_load = bus.if_ack && !rst;
                pc_we   = bus.if_ack && !rst;
            end
            S_DECODE: err_ill = !is_legal;
            S_EXECUTE: begin
                if (op_q == OP_RR) begin
                    alu_op = 2'b01;
                    cc_en  = 1'b1;
                end else if (op_q == OP_RI) begin
                    alu_op = 2'b10;
                    cc_en  = 1'b1;
                end else if (op_q == OP_MEM) begin
                    alu_op = 2'b10;
                end else if (op_q == OP_BR) begin
                    pc_we  = br_taken;
                    pc_sel = br_taken;
                end
            end
            S_MEM: begin
                dm_req  = 1'b1;
                dm_we   = is_store;
                err_tmo = tmo_hit;
            end
            S_WRITEBACK: begin
                rf_we  = 1'b1;
                wb_sel = (op_q == OP_MEM);
                rd_sel = (op_q == OP_RI) || (op_q == OP_MEM);
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.if_req    = if_req;
    assign bus.ir_load   = ir_load;
    assign bus.pc_we     = pc_we;
    assign bus.pc_sel    = pc_sel;
    assign bus.alu_op    = alu_op;
    assign bus.cc_en     = cc_en;
    assign bus.dm_req    = dm_req;
    assign bus.dm_we     = dm_we;
    assign bus.rf_we     = rf_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.rd_sel    = rd_sel;
    assign bus.halted    = halted;
    assign bus.err_ill   = err_ill;
    assign bus.err_tmo   = err_tmo;
    assign bus.instr_cnt = instr_cnt;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Directed scoreboard bench for sisc_mc_ctrl: each stimulus cycle queues the expected
// output snapshot, and a negedge monitor pops and compares it.
module tb_sisc_mc_ctrl;
    localparam int W = 17;

    // Control snapshot bits, MSB first:
    // if_req ir_load pc_we pc_sel alu_op[1:0] cc_en dm_req dm_we rf_we wb_sel rd_sel halted err_ill err_tmo
    localparam logic [14:0] E_FW     = 15'h4000;
    localparam logic [14:0] E_FA     = 15'h7000;
    localparam logic [14:0] E_DEC    = 15'h0000;
    localparam logic [14:0] E_EX_RR  = 15'h0300;
    localparam logic [14:0] E_EX_RI  = 15'h0500;
    localparam logic [14:0] E_EX_MEM = 15'h0400;
    localparam logic [14:0] E_BR_T   = 15'h1800;
    localparam logic [14:0] E_BR_N   = 15'h0000;
    localparam logic [14:0] E_MEM_LD = 15'h0080;
    localparam logic [14:0] E_MEM_ST = 15'h00C0;
    localparam logic [14:0] E_TMO_ST = 15'h00C1;
    localparam logic [14:0] E_WB_RR  = 15'h0020;
    localparam logic [14:0] E_WB_RI  = 15'h0028;
    localparam logic [14:0] E_WB_LD  = 15'h0038;
    localparam logic [14:0] E_HALT   = 15'h0004;
    localparam logic [14:0] E_ILL    = 15'h0002;

    logic clk;
    logic rst;

    sisc_mc_ctrl_if #(.OPC_W(4), .MM_W(4), .CC_W(4), .CNT_W(2)) bus ();

    sisc_mc_ctrl #(
        .OPC_W(4), .MM_W(4), .CC_W(4), .MEM_TMO(15), .CNT_W(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [1:0]   cnt_model = 2'd0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            string        nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {bus.if_req, bus.ir_load, bus.pc_we, bus.pc_sel, bus.alu_op, bus.cc_en,
                     bus.dm_req, bus.dm_we, bus.rf_we, bus.wb_sel, bus.rd_sel, bus.halted,
                     bus.err_ill, bus.err_tmo, bus.instr_cnt};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s: got ctl=%h cnt=%0d expected ctl=%h cnt=%0d",
                         nm, act_v[W-1:2], act_v[1:0], exp_v[W-1:2], exp_v[1:0]);
            end
        end
    end

    // driver tasks
    task automatic step(input string nm, input logic ack, input logic [3:0] op,
                        input logic [3:0] m, input logic [3:0] st, input logic dack,
                        input logic [14:0] ctl);
        bus.if_ack = ack;
        bus.opcode = op;
        bus.mm     = m;
        bus.stat   = st;
        bus.dm_ack = dack;
        exp_q.push_back({ctl, cnt_model});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [14:0] ctl);
        step(nm, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, ctl);
    endtask

    task automatic fetch_dec(input string nm, input logic [3:0] op, input logic [3:0] m);
        step(nm, 1'b1, op, m, 4'h0, 1'b0, E_FA);
        idle(nm, E_DEC);
    endtask

    task automatic retire();
        if (cnt_model != 2'd3) cnt_model = cnt_model + 2'd1;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_ack = 1'b0;
        bus.opcode = '0;
        bus.mm     = '0;
        bus.stat   = '0;
        bus.dm_ack = 1'b0;
        @(posedge clk);
        #1;

        // reset values, ack during reset ignored
        step("reset", 1'b1, 4'h1, 4'h0, 4'h0, 1'b1, E_FW);
        step("reset", 1'b1, 4'h1, 4'h0, 4'h0, 1'b1, E_FW);
        rst = 1'b0;

        // ALU reg-reg: 4 cycles
        fetch_dec("alu_rr", 4'h1, 4'h0);
        idle("alu_rr_ex", E_EX_RR);
        idle("alu_rr_wb", E_WB_RR);
        retire();

        // load with 3 wait cycles
        fetch_dec("load", 4'h3, 4'h0);
        idle("load_ex", E_EX_MEM);
        for (int i = 0; i < 3; i++) idle("load_wait", E_MEM_LD);
        step("load_ack", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, E_MEM_LD);
        idle("load_wb", E_WB_LD);
        retire();

        // store never acked: timeout on the 15th MEM cycle, not counted
        fetch_dec("st_tmo", 4'h3, 4'h1);
        idle("st_tmo_ex", E_EX_MEM);
        for (int i = 0; i < 14; i++) idle("st_tmo_wait", E_MEM_ST);
        idle("st_tmo_err", E_TMO_ST);
        idle("st_tmo_back", E_FW);

        // load acked exactly on the limit cycle: ack wins
        fetch_dec("ld_lim", 4'h3, 4'h0);
        idle("ld_lim_ex", E_EX_MEM);
        for (int i = 0; i < 14; i++) idle("ld_lim_wait", E_MEM_LD);
        step("ld_lim_ack", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, E_MEM_LD);
        idle("ld_lim_wb", E_WB_LD);
        retire();

        // store acked at once; counter already at 3 and must stick
        fetch_dec("store", 4'h3, 4'h1);
        idle("store_ex", E_EX_MEM);
        step("store_ack", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, E_MEM_ST);
        retire();
        idle("store_back", E_FW);

        // ALU reg-imm
        fetch_dec("alu_ri", 4'h2, 4'h0);
        idle("alu_ri_ex", E_EX_RI);
        idle("alu_ri_wb", E_WB_RI);
        retire();

        // branches
        fetch_dec("br_hit", 4'h4, 4'h2);
        step("br_hit_ex", 1'b0, 4'h0, 4'h0, 4'h2, 1'b0, E_BR_T);
        retire();
        fetch_dec("br_miss", 4'h4, 4'h2);
        step("br_miss_ex", 1'b0, 4'h0, 4'h0, 4'h5, 1'b0, E_BR_N);
        retire();
        fetch_dec("br_always", 4'h4, 4'h0);
        step("br_always_ex", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, E_BR_T);
        retire();

        // illegal opcode and NOP
        step("illegal", 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, E_FA);
        idle("illegal_dec", E_ILL);
        idle("illegal_back", E_FW);
        fetch_dec("nop", 4'h0, 4'h0);
        retire();
        idle("nop_back", E_FW);

        // reset mid-MEM, ack during reset ignored
        fetch_dec("rst_mem", 4'h3, 4'h0);
        idle("rst_mem_ex", E_EX_MEM);
        idle("rst_mem_wait", E_MEM_LD);
        rst = 1'b1;
        cnt_model = 2'd0;
        step("rst_mem_async", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, E_FW);
        step("rst_mem_hold", 1'b1, 4'h3, 4'h0, 4'h0, 1'b1, E_FW);
        rst = 1'b0;
        idle("rst_mem_after", E_FW);

        // HALT: counted once, held with fetch acks ignored
        fetch_dec("halt", 4'hF, 4'h0);
        retire();
        for (int i = 0; i < 20; i++) step("halt_hold", 1'b1, 4'h1, 4'h0, 4'h0, 1'b1, E_HALT);

        @(posedge clk);
        @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
